// File: rtl/branch_resolve_unit.sv
// Branch resolver: flag file with forwarding, condition decode, next-PC select and circular RAS.
// Decision registered: br_valid at edge N yields dec_valid/taken/target/flush in cycle N+1.
module branch_resolve_unit #(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 32,
   parameter int INSTR_BYTES = 4,
   parameter int RAS_DEPTH   = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          flag_we,
   input  logic [DATA_W-1:0]             result,
   input  logic                          carry_in,
   input  logic                          br_valid,
   input  logic [5:0]                    opcode,
   input  logic [ADDR_W-1:0]             pc,
   input  logic [ADDR_W-1:0]             offset,
   input  logic [ADDR_W-1:0]             reg_target,
   output logic                          dec_valid,
   output logic                          taken,
   output logic [ADDR_W-1:0]             target,
   output logic                          flush,
   output logic [$clog2(RAS_DEPTH):0]    ras_count,
   output logic                          ras_ovf,
   output logic                          ras_unf,
   output logic [2:0]                    flags_q
);

   localparam int PTR_W = $clog2(RAS_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

   localparam logic [5:0] OP_BLT  = 6'b001000;
   localparam logic [5:0] OP_BZ   = 6'b001001;
   localparam logic [5:0] OP_BNZ  = 6'b001010;
   localparam logic [5:0] OP_B    = 6'b001011;
   localparam logic [5:0] OP_CALL = 6'b001100;
   localparam logic [5:0] OP_JR   = 6'b001101;
   localparam logic [5:0] OP_BCY  = 6'b001110;
   localparam logic [5:0] OP_BNCY = 6'b001111;
   localparam logic [5:0] OP_RET  = 6'b010000;

   logic [2:0]        flags_new, flags_eff;
   logic              flag_z, flag_s, flag_c;
   logic [ADDR_W-1:0] fall_thru, rel_tgt, tos;
   logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
   logic [PTR_W-1:0]  ptr_q;
   logic [CNT_W-1:0]  cnt_q;

   logic              dec_valid_q, taken_q, flush_q, ovf_q, unf_q;
   logic [ADDR_W-1:0] target_q;

   logic              taken_d, unf_d, push, pop;
   logic [ADDR_W-1:0] taken_tgt, target_d;

   assign flags_new = {carry_in, result[DATA_W-1], (result == '0)};
   // Same-cycle ALU update is forwarded so a branch right behind its compare sees fresh flags.
   assign flags_eff = (flag_we && br_valid) ? flags_new : flags_q;
   assign flag_z    = flags_eff[0];
   assign flag_s    = flags_eff[1];
   assign flag_c    = flags_eff[2];

   assign fall_thru = pc + ADDR_W'(INSTR_BYTES);
   assign rel_tgt   = pc + offset;
   assign tos       = ras_mem[ptr_q - PTR_W'(1)];

   always_comb begin
      taken_d   = 1'b0;
      taken_tgt = rel_tgt;
      push      = 1'b0;
      pop       = 1'b0;
      unf_d     = 1'b0;
      case (opcode)
         OP_BLT:  taken_d = flag_s & ~flag_z;
         OP_BZ:   taken_d = flag_z;
         OP_BNZ:  taken_d = ~flag_z;
         OP_B:    taken_d = 1'b1;
         OP_CALL: begin
            taken_d = 1'b1;
            push    = br_valid;
         end
         OP_JR: begin
            taken_d   = 1'b1;
            taken_tgt = reg_target;
         end
         OP_BCY:  taken_d = flag_c;
         OP_BNCY: taken_d = ~flag_c;
         OP_RET: begin
            taken_tgt = tos;
            if (cnt_q != '0) begin
               taken_d = 1'b1;
               pop     = br_valid;
            end else begin
               unf_d   = br_valid;
            end
         end
         default: taken_d = 1'b0;
      endcase
      target_d = taken_d ? taken_tgt : fall_thru;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         flags_q     <= '0;
         dec_valid_q <= 1'b0;
         taken_q     <= 1'b0;
         flush_q     <= 1'b0;
         target_q    <= '0;
         unf_q       <= 1'b0;
         ovf_q       <= 1'b0;
         ptr_q       <= '0;
         cnt_q       <= '0;
      end else begin
         if (flag_we) flags_q <= flags_new;
         dec_valid_q <= br_valid;
         taken_q     <= br_valid & taken_d;
         flush_q     <= br_valid & taken_d;
         unf_q       <= unf_d;
         if (br_valid) target_q <= target_d;
         // A push while full wraps onto the oldest entry; depth stays saturated.
         if (push) begin
            ptr_q <= ptr_q + PTR_W'(1);
            if (cnt_q == CNT_FULL) ovf_q <= 1'b1;
            else                   cnt_q <= cnt_q + CNT_W'(1);
         end else if (pop) begin
            ptr_q <= ptr_q - PTR_W'(1);
            cnt_q <= cnt_q - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) ras_mem[ptr_q] <= fall_thru;
   end

   assign dec_valid = dec_valid_q;
   assign taken     = taken_q;
   assign flush     = flush_q;
   assign target    = target_q;
   assign ras_count = cnt_q;
   assign ras_ovf   = ovf_q;
   assign ras_unf   = unf_q;

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
Parametrised successor to the combinational jump-condition decoder. It holds a registered flag file (zero, sign, carry) updated by the ALU, with same-cycle forwarding. It resolves conditional and unconditional branches with one-cycle registered latency and computes the next-PC target. A circular return-address stack (RAS) supports call/return, and the block drives the pipeline flush request.

Parameters:
DATA_W, 32, width of ALU result used for flag generation
ADDR_W, 32, width of PC, offset and targets
INSTR_BYTES, 4, fall-through increment added to pc
RAS_DEPTH, 8, return-address stack entries (power of two, >=2)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
flag_we  in  1  load flag file from result/carry_in this cycle
result  in  DATA_W  ALU result; zero = (result==0), sign = result[DATA_W-1]
carry_in  in  1  ALU carry out
br_valid  in  1  branch instruction present this cycle
opcode  in  6  branch opcode
pc  in  ADDR_W  address of branch instruction
offset  in  ADDR_W  sign-extended relative displacement
reg_target  in  ADDR_W  absolute target for register jump
dec_valid  out  1  decision valid (one-cycle pulse)
taken  out  1  branch taken
target  out  ADDR_W  next PC (taken target or fall-through)
flush  out  1  = dec_valid & taken
ras_count  out  clog2(RAS_DEPTH)+1  live RAS entries
ras_ovf  out  1  sticky: push while full occurred
ras_unf  out  1  one-cycle pulse: return with empty RAS
flags_q  out  3  {carry, sign, zero} registered flags

Behaviour:
- Reset (rst=0, async): all outputs 0, flags_q=0, RAS pointer and count 0, ras_ovf cleared. Reset mid-operation discards any pending decision; the first cycle after release issues no dec_valid.
- Flag file: on rising clk with flag_we=1, flags_q <= {carry_in, result[DATA_W-1], result==0}; otherwise it holds.
- Effective flags for a branch: if flag_we and br_valid are high in the same cycle, use flags computed from the current result/carry_in (forwarding). Otherwise use flags_q.
- Latency: br_valid sampled at edge N drives dec_valid/taken/target/flush during cycle N+1. br_valid=0 gives dec_valid=0 and taken=0; target holds its last value.
- Conditions (Z, S, C = effective flags):
  - 001000 blt: S & ~Z
  - 001001 bz: Z
  - 001010 bnz: ~Z
  - 001011 b: always
  - 001100 call: always; push
  - 001101 jr: always
  - 001110 bcy: C
  - 001111 bncy: ~C
  - 010000 ret: always; pop
  - any other opcode: taken=0, dec_valid=1, target = fall-through.
- Target arithmetic, all modulo 2^ADDR_W:
  - relative ops (001000–001100, 001110, 001111): pc+offset
  - jr: reg_target
  - ret: top-of-stack entry
  - not taken: pc+INSTR_BYTES
- RAS push (call): stores pc+INSTR_BYTES at the write pointer and advances the pointer.
  - If not full: count increments.
  - If full: the oldest entry is overwritten (circular), count stays at RAS_DEPTH, ras_ovf set sticky.
- RAS pop (ret):
  - If count>0: target = most recent entry, pointer retreats, count decrements.
  - If count==0: taken=0, target = pc+INSTR_BYTES, ras_unf pulses with dec_valid, pointer unchanged.
- Pointer wrap: modulo RAS_DEPTH in both directions.
- Only one branch op is accepted per cycle, so a push and a pop cannot occur together.
- A call immediately followed by ret on the next cycle returns the just-pushed address; the RAS write is visible to the next cycle's read.

Test Plan:
- Reset release, then flag_we with result=0 → flags_q=3'b001. Next cycle br_valid opcode=001001, pc=0x100, offset=0x20 → cycle after: dec_valid=1, taken=1, target=0x120, flush=1.
- Forwarding: flags_q has Z=1; same cycle flag_we result=0x80000000 and br_valid opcode=001000, pc=0x40, offset=0xFFFFFFF0 → taken=1, target=0x30.
- Carry pair: flag_we carry_in=1, then bcy pc=0x200 offset=8 → taken, target 0x208. Then bncy pc=0x300 → not taken, target 0x304, flush=0.
- RAS fill/overflow with RAS_DEPTH=8: 9 calls at pc=0x1000+16k → ras_count=8, ras_ovf=1. Then 8 rets → targets 0x1084, 0x1074 … down to 0x1014. A 9th ret → ras_unf pulse, taken=0.
- jr with reg_target=0xDEADBEE0 → target 0xDEADBEE0. Undefined opcode 0x3F → dec_valid=1, taken=0.
- Assert rst low between br_valid and its decision cycle → no dec_valid pulse, RAS empty, ras_ovf=0, all outputs 0.
